// File: rtl/drop_pkg.sv
// drop_pkg: shared state encoding and a constant-width helper for the drop controller.
`default_nettype none

package drop_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    CONFIRM = 3'd2,
    DROP    = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Bits needed to index 'value' distinct items (value >= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/window_avg.sv
// window_avg: DEPTH-sample sliding window with a running sum and a registered round-half-up mean.
`default_nettype none

module window_avg
  import drop_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_avg,
  output logic             full
);

  localparam int LOG_D = clog2(DEPTH);
  localparam int SUM_W = WIDTH + LOG_D;
  localparam int CNT_W = clog2(DEPTH + 1);

  logic [WIDTH-1:0] win [DEPTH];
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] sum_next;
  logic [SUM_W-1:0] rounded;
  logic [CNT_W-1:0] fill_cnt;

  // Slots start at zero, so subtracting the oldest slot is also correct while filling.
  assign sum_next = sum + SUM_W'(in_data) - SUM_W'(win[DEPTH-1]);
  // DEPTH*(2^WIDTH-1) + DEPTH/2 still fits in SUM_W bits.
  assign rounded  = sum_next + SUM_W'(DEPTH / 2);
  assign full     = (fill_cnt == CNT_W'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) win[i] <= '0;
      sum       <= '0;
      fill_cnt  <= '0;
      out_valid <= 1'b0;
      out_avg   <= '0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        win[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) win[i] <= win[i-1];
        sum <= sum_next;
        if (!full) fill_cnt <= fill_cnt + CNT_W'(1);
        if (fill_cnt >= CNT_W'(DEPTH - 1)) begin
          out_valid <= 1'b1;
          out_avg   <= WIDTH'(rounded >> LOG_D);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/drop_controller.sv
// drop_controller: moving-average height tracker plus arm/confirm/drop/hold sequencer.
`default_nettype none

module drop_controller
  import drop_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int CONFIRM     = 3,
  parameter int HOLD_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               height_valid,
  input  logic [WIDTH-1:0]   height,
  input  logic               drop_en,
  input  logic [WIDTH-1:0]   t_lim,
  output logic               avg_valid,
  output logic [WIDTH-1:0]   avg_height,
  output logic               drop_active,
  output logic [STATE_W-1:0] state
);

  localparam int CONF_W = clog2(CONFIRM + 1);
  localparam int HOLD_W = clog2(HOLD_CYCLES + 1);

  drop_pkg::state_t  st;
  logic [CONF_W-1:0] conf_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              accept;
  logic              full;
  logic              in_lim;

  // A zero height flags a failed sensor; such strobes never reach the window.
  assign accept = height_valid && (height != '0);

  window_avg #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_window (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (accept),
    .in_data   (height),
    .out_valid (avg_valid),
    .out_avg   (avg_height),
    .full      (full)
  );

  assign in_lim = avg_valid && (avg_height <= t_lim);
  assign state  = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= drop_pkg::IDLE;
      conf_cnt    <= '0;
      hold_cnt    <= '0;
      drop_active <= 1'b0;
    end else begin
      case (st)
        drop_pkg::IDLE: begin
          if (drop_en && full) st <= drop_pkg::ARMED;
        end
        drop_pkg::ARMED: begin
          if (!drop_en) begin
            st       <= drop_pkg::IDLE;
            conf_cnt <= '0;
          end else if (in_lim) begin
            if (CONFIRM <= 1) begin
              st          <= drop_pkg::DROP;
              drop_active <= 1'b1;
              hold_cnt    <= '0;
            end else begin
              st       <= drop_pkg::CONFIRM;
              conf_cnt <= CONF_W'(1);
            end
          end
        end
        drop_pkg::CONFIRM: begin
          if (!drop_en) begin
            st       <= drop_pkg::IDLE;
            conf_cnt <= '0;
          end else if (avg_valid) begin
            if (!in_lim) begin
              st       <= drop_pkg::ARMED;
              conf_cnt <= '0;
            end else if (conf_cnt == CONF_W'(CONFIRM - 1)) begin
              st          <= drop_pkg::DROP;
              conf_cnt    <= '0;
              drop_active <= 1'b1;
              hold_cnt    <= '0;
            end else begin
              conf_cnt <= conf_cnt + CONF_W'(1);
            end
          end
        end
        drop_pkg::DROP: begin
          // drop_en is ignored here: a started drop always runs its full hold.
          if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
            st          <= drop_pkg::DONE;
            drop_active <= 1'b0;
            hold_cnt    <= '0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        drop_pkg::DONE: begin
          if (!drop_en) st <= drop_pkg::IDLE;
        end
        default: begin
          st          <= drop_pkg::IDLE;
          conf_cnt    <= '0;
          hold_cnt    <= '0;
          drop_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_drop_controller.sv
// tb_drop_controller: directed stimulus with a queue-based average scoreboard and FSM checks.
`default_nettype none

module tb_drop_controller;

  localparam int S_IDLE    = 0;
  localparam int S_ARMED   = 1;
  localparam int S_CONFIRM = 2;
  localparam int S_DROP    = 3;
  localparam int S_DONE    = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       height_valid = 1'b0;
  logic [7:0] height = 8'd0;
  logic       drop_en = 1'b0;
  logic [7:0] t_lim = 8'd0;
  logic       avg_valid;
  logic [7:0] avg_height;
  logic       drop_active;
  logic [2:0] state;

  int total = 0;
  int bad = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  drop_controller #(
    .WIDTH       (8),
    .DEPTH       (4),
    .CONFIRM     (3),
    .HOLD_CYCLES (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .height_valid (height_valid),
    .height       (height),
    .drop_en      (drop_en),
    .t_lim        (t_lim),
    .avg_valid    (avg_valid),
    .avg_height   (avg_height),
    .drop_active  (drop_active),
    .state        (state)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every avg_valid pulse must match the oldest queued expectation.
  always @(posedge clk) begin
    int e;
    #1;
    if (avg_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_avg_valid: got avg=%0d, expected no pulse", avg_height);
      end else begin
        e = exp_q.pop_front();
        if (int'(avg_height) != e) begin
          bad++;
          $display("FAIL avg_height: got %0d, expected %0d", avg_height, e);
        end
      end
    end
  end

  // One-cycle strobe; exp < 0 means no average is expected for this sample.
  task automatic send(input int h, input int exp);
    @(negedge clk);
    height_valid = 1'b1;
    height       = 8'(h);
    if (exp >= 0) exp_q.push_back(exp);
    @(negedge clk);
    height_valid = 1'b0;
    height       = 8'd0;
  endtask

  task automatic step_chk(input string name, input int exp_state);
    @(negedge clk);
    chk(name, int'(state), exp_state);
  endtask

  task automatic measure_drop(input string name);
    int n;
    n = 0;
    while (drop_active && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk(name, n, 16);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_avg_valid", int'(avg_valid), 0);
    chk("rst_avg_height", int'(avg_height), 0);
    chk("rst_drop_active", int'(drop_active), 0);
    chk("rst_state", int'(state), S_IDLE);
    rst_n = 1'b1;

    // Fill the window: only the fourth sample yields an average.
    send(10, -1); send(20, -1); send(30, -1); send(41, 25);

    // Sensor-failure strobe is discarded.
    send(0, -1);
    @(negedge clk);
    chk("avg_after_zero", int'(avg_height), 25);

    // Window to all 30, then confirm three in-threshold averages.
    send(30, 30); send(30, 33); send(30, 33); send(30, 30);
    drop_en = 1'b1;
    t_lim   = 8'd20;
    step_chk("arm", S_ARMED);
    send(10, 25); step_chk("armed_above_lim", S_ARMED);
    send(10, 20); step_chk("confirm_1", S_CONFIRM);
    send(0, -1);  step_chk("zero_keeps_confirm", S_CONFIRM);
    send(10, 15); step_chk("confirm_2", S_CONFIRM);
    send(10, 10);
    @(negedge clk);
    chk("drop_state", int'(state), S_DROP);
    chk("drop_rise", int'(drop_active), 1);
    measure_drop("drop_len");
    chk("done_state", int'(state), S_DONE);
    step_chk("done_hold", S_DONE);
    drop_en = 1'b0;
    step_chk("done_exit", S_IDLE);

    // Out-of-threshold average drops back to ARMED and restarts the count.
    drop_en = 1'b1;
    step_chk("rearm", S_ARMED);
    send(30, 15);  step_chk("c3_conf_1", S_CONFIRM);
    send(10, 15);  step_chk("c3_conf_2", S_CONFIRM);
    send(110, 40); step_chk("c3_back_armed", S_ARMED);
    t_lim = 8'd50;
    send(10, 40);  step_chk("restart_1", S_CONFIRM);
    send(10, 35);  step_chk("restart_2", S_CONFIRM);

    // drop_en falls together with the qualifying sample.
    send(10, 35);
    drop_en = 1'b0;
    @(negedge clk);
    chk("abort_state", int'(state), S_IDLE);
    chk("abort_no_drop", int'(drop_active), 0);
    repeat (3) @(negedge clk);
    chk("abort_still_no_drop", int'(drop_active), 0);

    // drop_en falls mid-DROP: full hold, then straight to IDLE.
    drop_en = 1'b1;
    step_chk("arm_b", S_ARMED);
    send(10, 10); send(10, 10); send(10, 10);
    @(negedge clk);
    chk("drop_b_rise", int'(drop_active), 1);
    drop_en = 1'b0;
    measure_drop("drop_b_len");
    chk("drop_b_done", int'(state), S_DONE);
    step_chk("drop_b_idle", S_IDLE);

    // Asynchronous reset in the middle of a hold.
    drop_en = 1'b1;
    step_chk("arm_c", S_ARMED);
    send(10, 10); send(10, 10); send(10, 10);
    @(negedge clk);
    chk("drop_c_rise", int'(drop_active), 1);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_drop_low", int'(drop_active), 0);
    chk("async_state_idle", int'(state), S_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    send(40, -1); send(40, -1); send(40, -1);
    step_chk("no_arm_unfilled", S_IDLE);
    send(40, 40);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
